// File: rtl/io_register_controller_if.sv
// Register bus between lisp_core and the I/O controller.
// The core drives index/strobes/data; the controller returns read data.
interface io_register_controller_if;
   logic [6:0]  register_index;
   logic        register_read;
   logic        register_write;
   logic [15:0] register_write_value;
   logic [15:0] register_read_value;

   modport master (
      output register_index,
      output register_read,
      output register_write,
      output register_write_value,
      input  register_read_value
   );

   modport slave (
      input  register_index,
      input  register_read,
      input  register_write,
      input  register_write_value,
      output register_read_value
   );
endinterface

// File: rtl/io_register_controller.sv
// Memory-mapped I/O for lisp_core: LED register, prescaled timer,
// 8N1 UART transmitter and registered read-back.
module io_register_controller #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                     clk,
   input  logic                     reset,
   io_register_controller_if.slave  bus,
   output logic [7:0]               led_out,
   output logic                     uart_tx
);

   localparam logic [6:0]  IDX_LED      = 7'd0;
   localparam logic [6:0]  IDX_STATUS   = 7'd1;
   localparam logic [6:0]  IDX_DATA     = 7'd2;
   localparam logic [6:0]  IDX_TIMER    = 7'd3;
   localparam logic [6:0]  IDX_PRESCALE = 7'd4;
   localparam logic [15:0] BAUD_LAST    = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } uart_state_e;

   uart_state_e state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  led_q, led_d;
   logic [15:0] tick_q, tick_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] rdata_q, rdata_d;

   logic        wr_led;
   logic        wr_data;
   logic        wr_timer;
   logic        wr_prescale;
   logic        rd_status;
   logic        tx_busy;
   logic        baud_last;
   logic        pwrap;
   logic [15:0] rd_mux;

   assign wr_led      = bus.register_write &&
                        (bus.register_index == IDX_LED);
   assign wr_data     = bus.register_write &&
                        (bus.register_index == IDX_DATA);
   assign wr_timer    = bus.register_write &&
                        (bus.register_index == IDX_TIMER);
   assign wr_prescale = bus.register_write &&
                        (bus.register_index == IDX_PRESCALE);
   assign rd_status   = bus.register_read &&
                        (bus.register_index == IDX_STATUS);

   assign tx_busy   = (state_q != S_IDLE);
   assign baud_last = (baud_q == BAUD_LAST);

   // UART transmitter; tx is registered so the line drops on the accepting edge
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (wr_data) begin
               state_d = S_START;
               baud_d  = '0;
               shift_d = bus.register_write_value[7:0];
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_last) begin
               state_d = S_IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // A dropped byte outranks a status read clearing the flag
   always_comb begin
      overrun_d = overrun_q;
      if (wr_data && tx_busy) begin
         overrun_d = 1'b1;
      end else if (rd_status) begin
         overrun_d = 1'b0;
      end
   end

   always_comb begin
      led_d = led_q;
      if (wr_led) begin
         led_d = bus.register_write_value[7:0];
      end
   end

   // Counter also wraps at all-ones so a lowered PRESCALE cannot strand it
   assign pwrap = (pcnt_q == prescale_q) || (pcnt_q == 16'hFFFF);

   always_comb begin
      pcnt_d     = pcnt_q + 16'd1;
      tick_d     = tick_q;
      prescale_d = prescale_q;
      if (pwrap) begin
         pcnt_d = '0;
         tick_d = tick_q + 16'd1;
      end
      if (wr_prescale) begin
         prescale_d = bus.register_write_value;
      end
      if (wr_timer) begin
         pcnt_d = '0;
         tick_d = '0;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.register_index)
         IDX_LED:      rd_mux = {8'h00, led_q};
         IDX_STATUS:   rd_mux = {14'd0, overrun_q, tx_busy};
         IDX_TIMER:    rd_mux = tick_q;
         IDX_PRESCALE: rd_mux = prescale_q;
         default:      rd_mux = '0;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (bus.register_read) begin
         rdata_d = rd_mux;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overrun_q  <= 1'b0;
         led_q      <= '0;
         tick_q     <= '0;
         pcnt_q     <= '0;
         prescale_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overrun_q  <= overrun_d;
         led_q      <= led_d;
         tick_q     <= tick_d;
         pcnt_q     <= pcnt_d;
         prescale_q <= prescale_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.register_read_value = rdata_q;
   assign led_out                 = led_q;
   assign uart_tx                 = tx_q;

endmodule

// File: tb/tb_io_register_controller.sv
// Scoreboarded bench for io_register_controller (CLKS_PER_BIT=4).
// Inputs change on negedge; outputs are checked on negedge.
module tb_io_register_controller;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] led_out;
   logic       uart_tx;

   io_register_controller_if bus ();

   io_register_controller #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .led_out (led_out),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] e;
   logic [9:0]  frame;

   // Sets inputs for the next rising edge
   task automatic drv(input logic rd, input logic wr,
                      input logic [6:0] idx, input logic [15:0] val);
      @(negedge clk);
      bus.register_read        = rd;
      bus.register_write       = wr;
      bus.register_index       = idx;
      bus.register_write_value = val;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drv(0, 0, 0, 0);
      drv(0, 0, 0, 0);
      n_cmp++;
      if (led_out !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_led: got %h want 00", led_out);
      end
      n_cmp++;
      if (uart_tx !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_tx: got %b want 1", uart_tx);
      end
      n_cmp++;
      if (bus.register_read_value !== 16'h0000) begin
         n_bad++;
         $display("FAIL rst_rdata: got %h want 0000",
                  bus.register_read_value);
      end
      reset = 1'b0;
   endtask

   task automatic test_led;
      drv(0, 1, 0, 16'h12A5);
      drv(0, 0, 0, 0);
      n_cmp++;
      if (led_out !== 8'hA5) begin
         n_bad++;
         $display("FAIL led_out: got %h want a5", led_out);
      end
      drv(1, 0, 0, 0);
      exp_q.push_back(16'h00A5);
      drv(1, 0, 7'd77, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL led_rd: got %h want %h",
                  bus.register_read_value, e);
      end
      exp_q.push_back(16'h0000);
      drv(0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL unmapped_rd: got %h want %h",
                  bus.register_read_value, e);
      end
   endtask

   task automatic test_rw_same_cycle;
      drv(1, 1, 0, 16'h003C);
      exp_q.push_back(16'h00A5);
      drv(0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL rw_old: got %h want %h",
                  bus.register_read_value, e);
      end
      n_cmp++;
      if (led_out !== 8'h3C) begin
         n_bad++;
         $display("FAIL rw_new: got %h want 3c", led_out);
      end
   endtask

   task automatic test_uart_frame;
      logic rd;
      logic pend;
      pend  = 1'b0;
      frame = {1'b1, 8'h53, 1'b0};
      drv(0, 1, 2, 16'h0053);
      for (int k = 0; k < 46; k++) begin
         rd = (k == 4) || (k == 40);
         drv(rd, 0, 1, 0);
         if (pend) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.register_read_value !== e) begin
               n_bad++;
               $display("FAIL frame_status k=%0d: got %h want %h",
                        k, bus.register_read_value, e);
            end
         end
         if (k < 40 && (k % CPB) == CPB / 2) begin
            n_cmp++;
            if (uart_tx !== frame[k / CPB]) begin
               n_bad++;
               $display("FAIL frame_bit%0d: got %b want %b",
                        k / CPB, uart_tx, frame[k / CPB]);
            end
         end
         pend = rd;
         if (rd) exp_q.push_back((k == 4) ? 16'h0001 : 16'h0000);
      end
   endtask

   task automatic test_overrun;
      logic rd;
      logic wr;
      logic pend;
      logic [15:0] wv;
      logic [15:0] ev;
      pend  = 1'b0;
      frame = {1'b1, 8'h53, 1'b0};
      drv(0, 1, 2, 16'h0053);
      for (int k = 0; k < 46; k++) begin
         rd = 1'b0;
         wr = 1'b0;
         wv = 16'h0000;
         ev = 16'h0000;
         case (k)
            2:  begin wr = 1'b1; wv = 16'h00FF; end
            9:  begin rd = 1'b1; ev = 16'h0003; end
            10: begin rd = 1'b1; ev = 16'h0001; end
            19: begin wr = 1'b1; wv = 16'h0000; end
            20: begin rd = 1'b1; ev = 16'h0003; end
            21: begin rd = 1'b1; ev = 16'h0001; end
            39: begin wr = 1'b1; wv = 16'h00AA; end
            41: begin rd = 1'b1; ev = 16'h0002; end
            42: begin rd = 1'b1; ev = 16'h0000; end
            default: ;
         endcase
         drv(rd, wr, wr ? 7'd2 : 7'd1, wv);
         if (pend) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.register_read_value !== e) begin
               n_bad++;
               $display("FAIL ovr_status k=%0d: got %h want %h",
                        k, bus.register_read_value, e);
            end
         end
         if (k < 40 && (k % CPB) == CPB / 2) begin
            n_cmp++;
            if (uart_tx !== frame[k / CPB]) begin
               n_bad++;
               $display("FAIL ovr_bit%0d: got %b want %b",
                        k / CPB, uart_tx, frame[k / CPB]);
            end
         end
         if (k > 40) begin
            n_cmp++;
            if (uart_tx !== 1'b1) begin
               n_bad++;
               $display("FAIL ovr_idle_tx k=%0d: got %b want 1",
                        k, uart_tx);
            end
         end
         pend = rd;
         if (rd) exp_q.push_back(ev);
      end
   endtask

   task automatic test_timer;
      int pre;
      int d;
      pre = 3;
      d   = 41;
      drv(0, 1, 4, 16'(pre));
      drv(0, 1, 3, 0);
      repeat (d - 1) drv(0, 0, 0, 0);
      drv(1, 0, 3, 0);
      exp_q.push_back(16'((d - 1) / (pre + 1)));
      drv(1, 0, 4, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL timer_ticks: got %0d want %0d",
                  bus.register_read_value, e);
      end
      exp_q.push_back(16'(pre));
      drv(0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL prescale_rd: got %h want %h",
                  bus.register_read_value, e);
      end
   endtask

   task automatic test_timer_wrap;
      drv(0, 1, 4, 0);
      drv(0, 1, 3, 0);
      drv(1, 0, 3, 0);
      exp_q.push_back(16'h0000);
      drv(0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL clear_wins: got %h want %h",
                  bus.register_read_value, e);
      end
      repeat (65533) drv(0, 0, 0, 0);
      drv(1, 0, 3, 0);
      exp_q.push_back(16'hFFFF);
      drv(1, 0, 3, 0);
      exp_q.push_back(16'h0000);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL wrap_max: got %h want %h",
                  bus.register_read_value, e);
      end
      drv(0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL wrap_zero: got %h want %h",
                  bus.register_read_value, e);
      end
   endtask

   task automatic test_reset_mid;
      drv(0, 1, 0, 16'h00A5);
      drv(1, 0, 0, 0);
      exp_q.push_back(16'h00A5);
      drv(0, 1, 4, 16'h0002);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL pre_rst_led: got %h want %h",
                  bus.register_read_value, e);
      end
      drv(0, 1, 2, 16'h0000);
      drv(0, 1, 2, 16'h0011);
      drv(0, 0, 0, 0);
      reset = 1'b1;
      n_cmp++;
      if (uart_tx !== 1'b0) begin
         n_bad++;
         $display("FAIL pre_rst_tx: got %b want 0", uart_tx);
      end
      drv(1, 0, 3, 0);
      reset = 1'b0;
      exp_q.push_back(16'h0000);
      n_cmp++;
      if (led_out !== 8'h00) begin
         n_bad++;
         $display("FAIL mid_rst_led: got %h want 00", led_out);
      end
      n_cmp++;
      if (uart_tx !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_rst_tx: got %b want 1", uart_tx);
      end
      n_cmp++;
      if (bus.register_read_value !== 16'h0000) begin
         n_bad++;
         $display("FAIL mid_rst_rdata: got %h want 0000",
                  bus.register_read_value);
      end
      drv(1, 0, 1, 0);
      exp_q.push_back(16'h0000);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL mid_rst_timer: got %h want %h",
                  bus.register_read_value, e);
      end
      drv(1, 0, 4, 0);
      exp_q.push_back(16'h0000);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL mid_rst_status: got %h want %h",
                  bus.register_read_value, e);
      end
      drv(0, 0, 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.register_read_value !== e) begin
         n_bad++;
         $display("FAIL mid_rst_prescale: got %h want %h",
                  bus.register_read_value, e);
      end
      repeat (6) drv(0, 0, 0, 0);
      n_cmp++;
      if (uart_tx !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_rst_abandon: got %b want 1", uart_tx);
      end
   endtask

   initial begin
      reset                    = 1'b1;
      bus.register_read        = 1'b0;
      bus.register_write       = 1'b0;
      bus.register_index       = '0;
      bus.register_write_value = '0;
      test_reset;
      test_led;
      test_rw_same_cycle;
      test_uart_frame;
      test_overrun;
      test_timer;
      test_timer_wrap;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/io_register_controller.md
# io_register_controller

Memory-mapped I/O controller sitting on the lisp_core register bus (register_index / register_read / register_write / register_write_value / register_read_value). It decodes the 7-bit register index, owns the board LED output register, a prescaled free-running timer and an 8N1 UART transmitter, and returns registered read data to the core. It replaces the bare "latch every write to LEDs" glue in the FPGA top level.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per UART bit; legal range 2..65535.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- register_index  input  7  register address from lisp_core.
- register_read  input  1  read strobe, one cycle per access.
- register_write  input  1  write strobe, one cycle per access.
- register_write_value  input  16  write data.
- register_read_value  output  16  registered read data.
- led_out  output  8  LED register contents.
- uart_tx  output  1  serial line, idle high.

## Operation
- Register map, by register_index:
  - 0 LED: R/W; holds bits [7:0]; reads return {8'h00, led}.
  - 1 UART_STATUS: R; bit0 tx_busy, bit1 overrun (sticky), other bits 0. A read clears overrun after returning it. Writes are ignored.
  - 2 UART_DATA: W; bits [7:0] are the byte. If idle, the UART starts. If busy, the byte is dropped and overrun is set. Reads return 0.
  - 3 TIMER: R returns the 16-bit tick count. Any write clears both the tick count and the prescale counter.
  - 4 PRESCALE: R/W, 16 bits. A tick occurs every PRESCALE+1 clk cycles.
  - 5..127: reads return 0; writes are ignored.
- Timer:
  - The prescale counter counts 0..PRESCALE, then wraps to 0 and increments the tick count.
  - The tick count wraps from 0xFFFF to 0x0000.
  - A PRESCALE write does not reset the prescale counter. If the new value is below the current count, the next tick occurs when the counter wraps at 0xFFFF.
- UART FSM states:
  - IDLE (tx=1) -> START on an accepted write.
  - START (tx=0, CLKS_PER_BIT cycles) -> DATA.
  - DATA (8 bits, LSB first, CLKS_PER_BIT cycles each) -> STOP.
  - STOP (tx=1, CLKS_PER_BIT cycles) -> IDLE.
  - tx_busy = (state != IDLE).
- Simultaneous events:
  - Read and write in the same cycle: the write takes effect and the read returns the pre-write value.
  - An overrun set and a status-read clear in the same cycle: set wins.
  - A timer write coinciding with a tick: clear wins, count=0.
  - A UART_DATA write in the same cycle the FSM returns to IDLE counts as busy and sets overrun.

## Timing
- Reset values, one cycle after reset is sampled high:
  - register_read_value=0, led_out=0, uart_tx=1.
  - state=IDLE, overrun=0, tick count=0, prescale counter=0, PRESCALE=0.
- Reset mid-transmission: uart_tx=1 and the FSM is IDLE on the next cycle. The partial frame is abandoned.
- Read latency is 1 cycle:
  - register_read_value is updated on the edge that samples register_read.
  - It holds its value until the next read.
- Write latency is 1 cycle: led_out and the other registers update on the edge that samples register_write.
- UART start:
  - uart_tx goes low on the edge that accepts the write.
  - tx_busy reads as 1 from the next cycle.
  - A full frame is 10*CLKS_PER_BIT cycles, after which the FSM is IDLE.
- Timer with PRESCALE=0: the tick count increments every cycle.

## Test plan
- Reset: assert reset mid-frame with LED=0xA5 and TIMER running -> the next cycle shows led_out=0, uart_tx=1, and reads of TIMER, STATUS and PRESCALE all return 0.
- LED: write 0x12A5 to index 0 -> led_out=0xA5 next cycle; a read of index 0 returns 0x00A5. A read of index 77 returns 0.
- UART frame, CLKS_PER_BIT=4:
  - Write 0x53 to index 2 -> uart_tx samples at bit centres give 0, 1,1,0,0,1,0,1,0, 1.
  - STATUS reads 0x0001 during the frame and 0x0000 40 cycles after the write.
- Overrun: second write while busy -> the frame is unchanged. STATUS reads 0x0003, then 0x0001 on the immediate re-read. A clear coinciding with a new overrun leaves bit1=1.
- Timer: set PRESCALE=3 and write TIMER -> a read 40 cycles later returns 10.
- Timer wrap: at PRESCALE=0, after 65536 cycles from clear -> the count returns to 0.
- Simultaneous read/write of index 0: old value returned; new value visible on led_out.
